// File: rtl/instr_encoder_pkg.sv
// Shared RV32I ALU-encoding constants and the team ALU code lookup used by
// the encoder and the decoder.
package instr_encoder_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SLL  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_XOR  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    typedef struct packed {
        logic       legal;
        logic [2:0] funct3;
        logic       alt;     // SUB/SRA variant: selects FUNCT7_ALT
    } alu_decode_t;

    function automatic alu_decode_t alu_decode(input logic [3:0] op);
        alu_decode_t d;
        d = '{legal: 1'b1, funct3: F3_ADD_SUB, alt: 1'b0};
        case (op)
            ALU_ADD:  d.funct3 = F3_ADD_SUB;
            ALU_SUB:  begin d.funct3 = F3_ADD_SUB; d.alt = 1'b1; end
            ALU_SLL:  d.funct3 = F3_SLL;
            ALU_SLT:  d.funct3 = F3_SLT;
            ALU_SLTU: d.funct3 = F3_SLTU;
            ALU_XOR:  d.funct3 = F3_XOR;
            ALU_SRL:  d.funct3 = F3_SRL_SRA;
            ALU_SRA:  begin d.funct3 = F3_SRL_SRA; d.alt = 1'b1; end
            ALU_OR:   d.funct3 = F3_OR;
            ALU_AND:  d.funct3 = F3_AND;
            default:  d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Show-ahead synchronous FIFO holding encoded instruction words; the head
// entry is visible on rdata_o whenever empty_o is low.
module instr_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    // Extra pointer MSB distinguishes full from empty when indices match.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/instr_encoder.sv
// RV32I R/I-type ALU instruction encoder with buffered, address-tagged output
// and illegal-request reporting.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_alu_op,
    input  logic        in_imm_sel,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [11:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        err_illegal,
    output logic [7:0]  err_count
);
    alu_decode_t dec;
    logic        illegal;
    logic [6:0]  imm_hi;
    logic [31:0] enc_word;

    logic        fifo_full, fifo_empty;
    logic [31:0] fifo_head;
    logic        accept, push, pop;

    logic [31:0] addr_q, addr_d;
    logic [31:0] last_q, last_d;
    logic        err_pulse_q, err_pulse_d;
    logic [7:0]  err_cnt_q, err_cnt_d;

    always_comb begin
        dec     = alu_decode(in_alu_op);
        illegal = !dec.legal || ((in_alu_op == ALU_SUB) && in_imm_sel);
        // Shift immediates carry only shamt; the upper bits encode the variant.
        if ((in_alu_op == ALU_SLL) || (in_alu_op == ALU_SRL))
            imm_hi = FUNCT7_BASE;
        else if (in_alu_op == ALU_SRA)
            imm_hi = FUNCT7_ALT;
        else
            imm_hi = in_imm[11:5];
        if (in_imm_sel)
            enc_word = {imm_hi, in_imm[4:0], in_rs1, dec.funct3, in_rd, OPCODE_OP_IMM};
        else
            enc_word = {(dec.alt ? FUNCT7_ALT : FUNCT7_BASE), in_rs2, in_rs1,
                        dec.funct3, in_rd, OPCODE_OP};
    end

    assign in_ready  = !reset && !fifo_full;
    assign accept    = in_valid && in_ready;
    assign push      = accept && !illegal;
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;

    instr_fifo #(
        .WIDTH(32),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .wdata_i (enc_word),
        .pop_i   (pop),
        .rdata_o (fifo_head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    // last_q keeps the most recently transferred word visible while empty.
    assign out_instr   = fifo_empty ? last_q : fifo_head;
    assign out_addr    = addr_q;
    assign err_illegal = err_pulse_q;
    assign err_count   = err_cnt_q;

    always_comb begin
        addr_d      = addr_q;
        last_d      = last_q;
        err_pulse_d = accept && illegal;
        err_cnt_d   = err_cnt_q;
        if (pop) begin
            addr_d = addr_q + 32'd4;
            last_d = fifo_head;
        end
        if (accept && illegal && (err_cnt_q != '1))
            err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q      <= BASE_ADDR;
            last_q      <= '0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            addr_q      <= addr_d;
            last_q      <= last_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter FIFO_DEPTH, default 2: number of encoded words buffered, power of two, at least 2.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000: first output address, word-aligned.
REQ-003 The block SHALL provide `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL provide `reset`, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL provide `in_valid`, input, 1 bit: an encode request is present.
REQ-006 The block SHALL provide `in_ready`, output, 1 bit: the block can accept a request.
REQ-007 The block SHALL provide `in_alu_op`, input, 4 bits: ALU operation in the team ALU code map.
REQ-008 The block SHALL provide `in_imm_sel`, input, 1 bit: 1 selects I-type, 0 selects R-type.
REQ-009 The block SHALL provide `in_rd`, `in_rs1` and `in_rs2`, inputs, 5 bits each: register indices; `in_rs2` is ignored for I-type.
REQ-010 The block SHALL provide `in_imm`, input, 12 bits: the immediate; only bits [4:0] (shamt) are used for shifts.
REQ-011 The block SHALL provide `out_valid`, output, 1 bit: an encoded word is available.
REQ-012 The block SHALL provide `out_ready`, input, 1 bit: the consumer accepts the word.
REQ-013 The block SHALL provide `out_instr`, output, 32 bits: the RV32I instruction word.
REQ-014 The block SHALL provide `out_addr`, output, 32 bits: the instruction-memory byte address for `out_instr`.
REQ-015 The block SHALL provide `err_illegal`, output, 1 bit: one-cycle pulse marking a rejected request.
REQ-016 The block SHALL provide `err_count`, output, 8 bits: saturating count of rejected requests.

Function
REQ-017 ALU code map, `in_alu_op` to funct3:
- 0010 ADD -> 000
- 0100 SUB -> 000
- 0011 SLL -> 001
- 1000 SLT -> 010
- 0110 SLTU -> 011
- 0111 XOR -> 100
- 0101 SRL -> 101
- 1001 SRA -> 101
- 0001 OR -> 110
- 0000 AND -> 111
REQ-018 R-type encoding SHALL be opcode 0110011, funct7 = 0100000 for SUB/SRA and 0000000 otherwise, with fields {funct7, rs2, rs1, funct3, rd, opcode}.
REQ-019 I-type encoding SHALL be opcode 0010011 with fields {imm[11:0], rs1, funct3, rd, opcode}.
REQ-020 For SLLI/SRLI, imm[11:5] SHALL be forced to 0000000; for SRAI it SHALL be forced to 0100000.
REQ-021 The following requests SHALL be illegal:
- `in_alu_op` in 1010..1111;
- SUB with `in_imm_sel`=1.
REQ-022 The input handshake SHALL be `in_ready` = reset low AND FIFO not full, with no combinational path from `out_ready`; a request is accepted when `in_valid` && `in_ready`.
REQ-023 A legal accepted request SHALL be encoded combinationally and written into the FIFO at the accepting edge; `out_valid` SHALL rise the next cycle if the FIFO was empty (latency 1).
REQ-024 An illegal accepted request SHALL be consumed but not written; `err_illegal` SHALL be high for exactly the next cycle, and `err_count` SHALL increment and saturate at 255.
REQ-025 The output SHALL be FIFO-ordered: `out_instr` and `out_addr` reflect the head entry, a word transfers when `out_valid` && `out_ready`, and both stay stable while `out_valid` && !`out_ready`.
REQ-026 `out_addr` SHALL increment by 4 on each output transfer and wrap from 32'hFFFF_FFFC to 0.
REQ-027 A simultaneous push and pop SHALL leave occupancy unchanged; when full, no push occurs even if a pop happens that cycle.
REQ-028 While the FIFO is empty, `out_valid` SHALL be 0 and `out_instr` SHALL hold its last value.

Reset
REQ-029 While `reset` is high at a rising edge, the block SHALL set:
- FIFO occupancy to 0;
- `out_valid` to 0;
- `out_instr` to 0;
- `out_addr` to BASE_ADDR;
- `err_illegal` to 0;
- `err_count` to 0.
REQ-030 `in_ready` SHALL be 0 while `reset` is high and 1 in the first cycle after reset is released.
REQ-031 A reset asserted mid-stream SHALL discard all buffered words without emitting them.

Structure
REQ-032 A shared package SHALL hold:
- the ALU code localparams;
- the OPCODE_OP/OPCODE_OP_IMM constants;
- the FUNCT7_BASE/FUNCT7_ALT constants;
- the funct3 constants.
The existing decoder is refactored to use the same package.
REQ-033 The FIFO SHALL be a sub-module `instr_fifo` (parameterised by width and depth, storing {addr-independent instr}); encode logic, the address counter and the error counter stay in the top.

Verification
REQ-034 ADD rd=3, rs1=1, rs2=2, `out_ready`=1 -> `out_valid` 1 cycle later, `out_instr`=32'h002081B3, `out_addr`=0.
REQ-035 ADDI rd=1, rs1=0, imm=12'hFFF, then SRAI rd=5, rs1=6, imm=3 -> 32'hFFF00093 at addr 0, then 32'h40335293 at addr 4.
REQ-036 SUB rd=1, rs1=2, rs2=3 with `out_ready`=0 for 3 pushes -> `in_ready` drops after 2 accepts; on release, words appear in order at addresses 0, 4, 8, the first being 32'h403100B3.
REQ-037 `in_alu_op`=4'b1111, then SUB with `in_imm_sel`=1 -> two `err_illegal` pulses, `err_count`=2, `out_valid` never rises.
REQ-038 Fill the FIFO, then assert `reset` for 1 cycle -> `out_valid`=0, `out_addr`=BASE_ADDR, `err_count`=0; the next legal request emits at BASE_ADDR.
